ppu_vram_arbiter: RTL

//  Shares the single PPU memory port (CHR ROM $0000-$1FFF, VRAM $2000-$3EFF) between the renderer

---
 rtl/ppu_pkg.sv | 39 +++
 rtl/ppu_rd_tag_pipe.sv | 31 +++
 rtl/ppu_vram_arbiter.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/ppu_pkg.sv
// rtl/ppu_pkg.sv - shared types, address constants and nametable mirroring for the PPU VRAM arbiter
package ppu_pkg;

  typedef enum logic [1:0] {
    C_IDLE,
    C_BUSY,
    C_HOLD
  } cpu_arb_state_e;

  typedef enum logic {
    OWN_RND,
    OWN_CPU
  } owner_e;

  // Read tag carried alongside an outstanding memory read
  typedef struct packed {
    logic   valid;
    owner_e owner;
  } rd_tag_t;

  localparam logic [13:0] NT_BASE  = 14'h2000;
  localparam logic [13:0] PAL_BASE = 14'h3F00;

  // Fold $3xxx onto $2xxx and collapse the four nametables onto two physical pages.
  // Vertical keeps bit 10 as the page select; horizontal moves bit 11 into bit 10.
  function automatic logic [13:0] ppu_mirror_addr(input logic [13:0] addr, input logic mirror_v);
    logic [13:0] m;
    m = addr;
    if ((addr >= NT_BASE) && (addr < PAL_BASE)) begin
      m[12] = 1'b0;
      m[11] = 1'b0;
      if (!mirror_v) begin
        m[10] = addr[11];
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/ppu_rd_tag_pipe.sv
// rtl/ppu_rd_tag_pipe.sv - (RD_LAT+1)-deep shift register of read tags, asynchronously cleared
module ppu_rd_tag_pipe
  import ppu_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic    clk,
  input  logic    rst_n,
  input  rd_tag_t push,
  output rd_tag_t pop
);

  rd_tag_t pipe [RD_LAT+1];

  // Shift one tag per cycle; reset drops every in-flight read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i <= RD_LAT; i++) begin
        pipe[i] <= '{valid: 1'b0, owner: OWN_RND};
      end
    end else begin
      pipe[0] <= push;
      for (int i = 1; i <= RD_LAT; i++) begin
        pipe[i] <= pipe[i-1];
      end
    end
  end

  assign pop = pipe[RD_LAT];

endmodule

// File: rtl/ppu_vram_arbiter.sv
// rtl/ppu_vram_arbiter.sv - renderer/CPU arbiter for the PPU memory port; optional PPU_ARB_STARVE_GUARD_EN
module ppu_vram_arbiter
  import ppu_pkg::*;
#(
  parameter int RD_LAT     = 1,
  parameter int STARVE_MAX = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mirror_v,
  input  logic        rnd_req,
  input  logic [13:0] rnd_addr,
  output logic        rnd_gnt,
  output logic        rnd_rvalid,
  output logic [7:0]  rnd_rdata,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [13:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic        cpu_ack,
  output logic [7:0]  cpu_rdata,
  output logic [13:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_rw,
  input  logic [7:0]  mem_q
);

  cpu_arb_state_e state;
  cpu_arb_state_e next_state;

  logic    cpu_elig;
  logic    cpu_force;
  logic    cpu_gnt;
  logic    tag_exit_cpu;
  logic    tag_exit_rnd;
  rd_tag_t tag_push;
  rd_tag_t tag_pop;

  assign cpu_elig = (state == C_IDLE) && cpu_req;

`ifdef PPU_ARB_STARVE_GUARD_EN
  localparam int SW = $clog2(STARVE_MAX + 1);

  logic [SW-1:0] starve_cnt;

  assign cpu_force = cpu_elig && (starve_cnt == SW'(STARVE_MAX));

  // Count consecutive lost CPU arbitrations; any CPU grant restarts the count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (cpu_gnt) begin
      starve_cnt <= '0;
    end else if (cpu_elig && rnd_gnt) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end
`else
  logic unused_starve_max;

  assign unused_starve_max = (STARVE_MAX != 0);
  assign cpu_force         = 1'b0;
`endif

  // Renderer has priority unless the CPU is being forced through; nothing is granted in reset
  assign rnd_gnt = rst_n && rnd_req && !cpu_force;
  assign cpu_gnt = rst_n && cpu_elig && !rnd_gnt;

  // Only reads occupy the tag pipe; writes complete without waiting for memory
  assign tag_push.valid = rnd_gnt || (cpu_gnt && !cpu_we);
  assign tag_push.owner = rnd_gnt ? OWN_RND : OWN_CPU;

  ppu_rd_tag_pipe #(
    .RD_LAT(RD_LAT)
  ) u_tag_pipe (
    .clk  (clk),
    .rst_n(rst_n),
    .push (tag_push),
    .pop  (tag_pop)
  );

  assign tag_exit_cpu = tag_pop.valid && (tag_pop.owner == OWN_CPU);
  assign tag_exit_rnd = tag_pop.valid && (tag_pop.owner == OWN_RND);

  // Register the winner's request onto the memory port; the write strobe lasts one cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_rw    <= 1'b0;
    end else begin
      mem_rw <= 1'b0;
      if (rnd_gnt) begin
        mem_addr <= ppu_mirror_addr(rnd_addr, mirror_v);
      end else if (cpu_gnt) begin
        mem_addr <= ppu_mirror_addr(cpu_addr, mirror_v);
        mem_rw   <= cpu_we;
        if (cpu_we) begin
          mem_wdata <= cpu_wdata;
        end
      end
    end
  end

  // Capture memory data for whichever owner's tag leaves the pipe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rnd_rvalid <= 1'b0;
      rnd_rdata  <= '0;
      cpu_rdata  <= '0;
    end else begin
      rnd_rvalid <= tag_exit_rnd;
      if (tag_exit_rnd) begin
        rnd_rdata <= mem_q;
      end
      if (tag_exit_cpu) begin
        cpu_rdata <= mem_q;
      end
    end
  end

  // CPU access state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= C_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // CPU access sequencing; HOLD is the single ack cycle and ignores cpu_req
  always_comb begin
    next_state = state;
    cpu_ack    = 1'b0;
    case (state)
      C_IDLE: begin
        if (cpu_gnt) begin
          next_state = cpu_we ? C_HOLD : C_BUSY;
        end
      end
      C_BUSY: begin
        if (tag_exit_cpu) begin
          next_state = C_HOLD;
        end
      end
      C_HOLD: begin
        cpu_ack    = 1'b1;
        next_state = C_IDLE;
      end
      default: begin
        next_state = C_IDLE;
      end
    endcase
  end

endmodule
